alu_op_sequencer: RTL

- Initiator side of the 8-bit ALU interface: accepts operation commands over a valid/ready handshake.
- Drives registered A, B and SEL into the ALU, then waits a programmable settle time.
- Captures OUT, V and C and returns them over a second valid/ready handshake.
- Holds an 8-bit accumulator, sticky flags and an op counter, so the datapath can chain ALU operations without external glue.

---
 rtl/alu_op_sequencer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer
// Description : Initiator side of an 8-bit ALU interface. Accepts operation
//               commands over a valid/ready handshake, drives registered
//               A/B/SEL into the ALU, waits SETTLE_CYCLES edges, captures
//               OUT/V/C and returns them over a second valid/ready handshake.
//               Keeps an accumulator, sticky V/C flags and an op counter so
//               ALU operations can be chained without external glue.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   SETTLE_CYCLES : edges from accept to capture, legal range 1..15
// Ports
//   clk, rst                    : clock (rising edge), async active-high reset
//   cmd_valid / cmd_ready       : command handshake
//   cmd_a, cmd_b, cmd_sel       : operands and ALU operation select
//   cmd_acc                     : use accumulator instead of cmd_a
//   cmd_wb                      : write result into accumulator on capture
//   alu_a, alu_b, alu_sel       : registered drive into the ALU
//   alu_out, alu_v, alu_c       : ALU result and flags
//   res_valid / res_ready       : result handshake
//   res_out, res_v, res_c       : captured result and flags
//   acc                         : accumulator
//   v_sticky, c_sticky          : OR of captured flags since last clear
//   sticky_clr                  : clear sticky flags
//   ops_done                    : completed operation count (wraps)
// ============================================================================
module alu_op_sequencer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic [1:0] cmd_sel,
    input  logic       cmd_acc,
    input  logic       cmd_wb,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [1:0] alu_sel,
    input  logic [7:0] alu_out,
    input  logic       alu_v,
    input  logic       alu_c,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_out,
    output logic       res_v,
    output logic       res_c,
    output logic [7:0] acc,
    output logic       v_sticky,
    output logic       c_sticky,
    input  logic       sticky_clr,
    output logic [7:0] ops_done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;

    // Counter starts at SETTLE_CYCLES-1 so capture lands SETTLE_CYCLES edges
    // after the accept edge.
    localparam logic [3:0] C_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    logic [1:0] r_state;
    logic [3:0] r_cnt;
    logic       r_wb;
    logic       r_cmd_ready;
    logic [7:0] r_alu_a;
    logic [7:0] r_alu_b;
    logic [1:0] r_alu_sel;
    logic       r_res_valid;
    logic [7:0] r_res_out;
    logic       r_res_v;
    logic       r_res_c;
    logic [7:0] r_acc;
    logic       r_v_sticky;
    logic       r_c_sticky;
    logic [7:0] r_ops_done;

    logic       w_capture;

    assign w_capture = (r_state == S_SETTLE) && (r_cnt == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_wb        <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_alu_a     <= 8'd0;
            r_alu_b     <= 8'd0;
            r_alu_sel   <= 2'd0;
            r_res_valid <= 1'b0;
            r_res_out   <= 8'd0;
            r_res_v     <= 1'b0;
            r_res_c     <= 1'b0;
            r_acc       <= 8'd0;
            r_v_sticky  <= 1'b0;
            r_c_sticky  <= 1'b0;
            r_ops_done  <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        // Accumulator operand is the value before this op's
                        // own write-back.
                        r_alu_a     <= cmd_acc ? r_acc : cmd_a;
                        r_alu_b     <= cmd_b;
                        r_alu_sel   <= cmd_sel;
                        r_wb        <= cmd_wb;
                        r_cnt       <= C_SETTLE_LOAD;
                        r_cmd_ready <= 1'b0;
                        r_state     <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_res_out   <= alu_out;
                        r_res_v     <= alu_v;
                        r_res_c     <= alu_c;
                        r_res_valid <= 1'b1;
                        r_ops_done  <= r_ops_done + 8'd1;
                        if (r_wb) begin
                            r_acc <= alu_out;
                        end
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_res_valid <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase

            // A clear coincident with a capture takes effect first, so the
            // flags end up holding just the captured values.
            if (w_capture) begin
                r_v_sticky <= (r_v_sticky & ~sticky_clr) | alu_v;
                r_c_sticky <= (r_c_sticky & ~sticky_clr) | alu_c;
            end else if (sticky_clr) begin
                r_v_sticky <= 1'b0;
                r_c_sticky <= 1'b0;
            end
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_sel   = r_alu_sel;
    assign res_valid = r_res_valid;
    assign res_out   = r_res_out;
    assign res_v     = r_res_v;
    assign res_c     = r_res_c;
    assign acc       = r_acc;
    assign v_sticky  = r_v_sticky;
    assign c_sticky  = r_c_sticky;
    assign ops_done  = r_ops_done;

endmodule
`default_nettype wire
